// File: rtl/usb_xfer_sched.sv
// FT600 245 sync-FIFO transfer scheduler: round-robin read/write arbitration with a
// req/ack/done handshake and a turnaround gap. Define USB_SCHED_STAT_EN for word counters.
module usb_xfer_sched #(
    parameter int unsigned LVL_W     = 11,
    parameter int unsigned BURST_MAX = 256,
    parameter int unsigned LEN_W     = 9,
    parameter int unsigned TURN_CYC  = 2
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iENABLE,
    input  logic             iTXE_N,
    input  logic             iRXF_N,
    input  logic [LVL_W-1:0] iTX_LEVEL,
    input  logic [LVL_W-1:0] iRX_FREE,
    output logic             oREQ,
    output logic             oDIR,
    output logic [LEN_W-1:0] oLEN,
    input  logic             iACK,
    input  logic             iDONE,
    input  logic [LEN_W-1:0] iXFER_CNT,
    output logic             oBUSY,
    output logic             oERR,
    output logic [31:0]      oTX_WORDS,
    output logic [31:0]      oRX_WORDS
);
    localparam int unsigned TURN_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RUN  = 2'd2,
        S_TURN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                txe_meta_q, txe_s_q, rxf_meta_q, rxf_s_q;
    logic                req_q, req_d;
    logic                dir_q, dir_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                err_q, err_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic [TURN_W-1:0]   turn_q, turn_d;
    logic                rd_ok_c, wr_ok_c, sel_dir_c, fin_c;
    logic [LVL_W-1:0]    src_c;
    logic [LEN_W-1:0]    cap_len_c;

    // FTDI flags are asynchronous; synchronisers idle at the inactive level
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            txe_meta_q <= 1'b1;
            txe_s_q    <= 1'b1;
            rxf_meta_q <= 1'b1;
            rxf_s_q    <= 1'b1;
        end else begin
            txe_meta_q <= iTXE_N;
            txe_s_q    <= txe_meta_q;
            rxf_meta_q <= iRXF_N;
            rxf_s_q    <= rxf_meta_q;
        end
    end

    assign rd_ok_c   = ~rxf_s_q & (iRX_FREE != '0);
    assign wr_ok_c   = ~txe_s_q & (iTX_LEVEL != '0);
    assign sel_dir_c = (rd_ok_c & wr_ok_c) ? ~last_q : wr_ok_c;
    assign src_c     = sel_dir_c ? iTX_LEVEL : iRX_FREE;
    assign cap_len_c = (src_c > LVL_W'(BURST_MAX)) ? LEN_W'(BURST_MAX) : LEN_W'(src_c);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        dir_d   = dir_q;
        len_d   = len_q;
        err_d   = err_q;
        last_d  = last_q;
        turn_d  = turn_q;
        fin_c   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (iENABLE && (rd_ok_c || wr_ok_c)) begin
                    dir_d   = sel_dir_c;
                    len_d   = cap_len_c;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (iACK) begin
                    req_d = 1'b0;
                    if (iDONE) fin_c = 1'b1;
                    else       state_d = S_RUN;
                end else if (!iENABLE) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (iDONE) fin_c = 1'b1;
            end
            S_TURN: begin
                if (turn_q == '0) state_d = S_IDLE;
                else              turn_d  = turn_q - TURN_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
        // Burst completion: error check, round-robin update, start turnaround
        if (fin_c) begin
            if (iXFER_CNT > len_q) err_d = 1'b1;
            last_d  = dir_q;
            turn_d  = TURN_W'(TURN_CYC - 1);
            state_d = S_TURN;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            dir_q   <= 1'b0;
            len_q   <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b1;
            busy_q  <= 1'b0;
            turn_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            dir_q   <= dir_d;
            len_q   <= len_d;
            err_q   <= err_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            turn_q  <= turn_d;
        end
    end

    assign oREQ  = req_q;
    assign oDIR  = dir_q;
    assign oLEN  = len_q;
    assign oBUSY = busy_q;
    assign oERR  = err_q;

`ifdef USB_SCHED_STAT_EN
    logic [31:0] tx_words_q, tx_words_d, rx_words_q, rx_words_d;

    always_comb begin
        tx_words_d = tx_words_q;
        rx_words_d = rx_words_q;
        if (fin_c) begin
            if (dir_q) tx_words_d = tx_words_q + 32'(iXFER_CNT);
            else       rx_words_d = rx_words_q + 32'(iXFER_CNT);
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            tx_words_q <= '0;
            rx_words_q <= '0;
        end else begin
            tx_words_q <= tx_words_d;
            rx_words_q <= rx_words_d;
        end
    end

    assign oTX_WORDS = tx_words_q;
    assign oRX_WORDS = rx_words_q;
`else
    assign oTX_WORDS = '0;
    assign oRX_WORDS = '0;
`endif

endmodule

// File: tb/tb_usb_xfer_sched.sv
// Self-checking bench for usb_xfer_sched: vector table, corner-case sequences and
// randomized bursts against a transaction-level scheduler model.
module tb_usb_xfer_sched;
    localparam int unsigned LVL_W     = 11;
    localparam int unsigned LEN_W     = 9;
    localparam int unsigned BURST_MAX = 256;
    localparam int unsigned TURN_CYC  = 2;

    logic             iCLK = 1'b0;
    logic             iRESET;
    logic             iENABLE;
    logic             iTXE_N;
    logic             iRXF_N;
    logic [LVL_W-1:0] iTX_LEVEL;
    logic [LVL_W-1:0] iRX_FREE;
    logic             oREQ;
    logic             oDIR;
    logic [LEN_W-1:0] oLEN;
    logic             iACK;
    logic             iDONE;
    logic [LEN_W-1:0] iXFER_CNT;
    logic             oBUSY;
    logic             oERR;
    logic [31:0]      oTX_WORDS;
    logic [31:0]      oRX_WORDS;

    usb_xfer_sched dut (
        .iCLK      (iCLK),
        .iRESET    (iRESET),
        .iENABLE   (iENABLE),
        .iTXE_N    (iTXE_N),
        .iRXF_N    (iRXF_N),
        .iTX_LEVEL (iTX_LEVEL),
        .iRX_FREE  (iRX_FREE),
        .oREQ      (oREQ),
        .oDIR      (oDIR),
        .oLEN      (oLEN),
        .iACK      (iACK),
        .iDONE     (iDONE),
        .iXFER_CNT (iXFER_CNT),
        .oBUSY     (oBUSY),
        .oERR      (oERR),
        .oTX_WORDS (oTX_WORDS),
        .oRX_WORDS (oRX_WORDS)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        bit en;
        bit txe_n;
        bit rxf_n;
        int tx;
        int rx;
        bit exp_req;
        bit exp_dir;
        int exp_len;
    } vec_t;

    vec_t        vt [12];
    int          n_chk  = 0;
    int          n_pass = 0;
    bit          m_last;
    bit          m_err;
    logic [31:0] m_tx;
    logic [31:0] m_rx;

    function automatic vec_t mk(bit en, bit txe_n, bit rxf_n, int tx, int rx,
                                bit er, bit ed, int el);
        vec_t v;
        v.en = en; v.txe_n = txe_n; v.rxf_n = rxf_n; v.tx = tx; v.rx = rx;
        v.exp_req = er; v.exp_dir = ed; v.exp_len = el;
        return v;
    endfunction

    // Scheduler rules: eligibility, round-robin tie break, burst cap
    function automatic void predict(input bit en, input bit txe_n, input bit rxf_n,
                                    input int tx, input int rx,
                                    output bit req, output bit d, output int len);
        bit rd, wr;
        rd  = !rxf_n && (rx != 0);
        wr  = !txe_n && (tx != 0);
        req = en && (rd || wr);
        d   = (rd && wr) ? !m_last : wr;
        len = d ? tx : rx;
        if (len > int'(BURST_MAX)) len = int'(BURST_MAX);
    endfunction

    function automatic longint exp_tx();
`ifdef USB_SCHED_STAT_EN
        return longint'(m_tx);
`else
        return 0;
`endif
    endfunction

    function automatic longint exp_rx();
`ifdef USB_SCHED_STAT_EN
        return longint'(m_rx);
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic apply(input bit en, input bit txe_n, input bit rxf_n, input int tx, input int rx);
        iENABLE   = en;
        iTXE_N    = txe_n;
        iRXF_N    = rxf_n;
        iTX_LEVEL = LVL_W'(tx);
        iRX_FREE  = LVL_W'(rx);
    endtask

    task automatic wait_req(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (oREQ) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic settle();
        iTXE_N = 1'b1;
        iRXF_N = 1'b1;
        repeat (4) step();
    endtask

    // Acts as the bus engine for one granted burst; n = cycles from the done cycle to idle
    task automatic run_burst(input bit d, input int len, input int cnt, input bit ackdone,
                             output int n);
        chk("req_dir", oDIR, d);
        chk("req_len", oLEN, len);
        step();
        chk("req_hold", oREQ, 1);
        chk("dir_hold", oDIR, d);
        chk("len_hold", oLEN, len);
        iACK      = 1'b1;
        iDONE     = ackdone;
        iXFER_CNT = LEN_W'(cnt);
        step();
        iACK  = 1'b0;
        iDONE = 1'b0;
        chk("req_drop_on_ack", oREQ, 0);
        chk("busy_after_ack", oBUSY, 1);
        n = 1;
        if (!ackdone) begin
            repeat ($urandom_range(0, 2)) begin
                step();
                chk("busy_run", oBUSY, 1);
            end
            iDONE     = 1'b1;
            iXFER_CNT = LEN_W'(cnt);
            step();
            iDONE = 1'b0;
        end
        while (oBUSY && n < 10) begin
            step();
            n++;
        end
        if (cnt > len) m_err = 1'b1;
        m_last = d;
        if (d) m_tx = m_tx + 32'(cnt);
        else   m_rx = m_rx + 32'(cnt);
        chk("turnaround_len", n, TURN_CYC + 1);
        chk("err_flag", oERR, m_err);
        chk("tx_words", oTX_WORDS, exp_tx());
        chk("rx_words", oRX_WORDS, exp_rx());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with %0d of %0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, n, pl, act, tx, rx;
        bit pr, pd, en, txe_n, rxf_n;

        vt[0]  = mk(1, 0, 1,  100,  500, 1, 1, 100);
        vt[1]  = mk(1, 0, 0, 1000, 1000, 1, 0, 256);
        vt[2]  = mk(1, 0, 0, 1000, 1000, 1, 1, 256);
        vt[3]  = mk(1, 0, 0, 1000, 1000, 1, 0, 256);
        vt[4]  = mk(1, 1, 0,  500,    0, 0, 0,   0);
        vt[5]  = mk(1, 0, 0,    0,  256, 1, 0, 256);
        vt[6]  = mk(1, 1, 0,  900,  257, 1, 0, 256);
        vt[7]  = mk(1, 0, 1,    1,  900, 1, 1,   1);
        vt[8]  = mk(1, 0, 0, 2047,    5, 1, 0,   5);
        vt[9]  = mk(0, 0, 0,  300,  300, 0, 0,   0);
        vt[10] = mk(1, 0, 0,  255,    0, 1, 1, 255);
        vt[11] = mk(1, 0, 0,    3,    7, 1, 0,   7);

        m_last = 1'b1; m_err = 1'b0; m_tx = '0; m_rx = '0;
        iRESET = 1'b0; iACK = 1'b0; iDONE = 1'b0; iXFER_CNT = '0;
        apply(0, 1, 1, 0, 0);
        repeat (3) step();
        chk("rst_req", oREQ, 0);
        chk("rst_dir", oDIR, 0);
        chk("rst_len", oLEN, 0);
        chk("rst_busy", oBUSY, 0);
        chk("rst_err", oERR, 0);
        chk("rst_tx_words", oTX_WORDS, 0);
        chk("rst_rx_words", oRX_WORDS, 0);
        iRESET = 1'b1;
        repeat (2) step();

        // Vector table: one arbitration decision per record
        for (int i = 0; i < 12; i++) begin
            apply(vt[i].en, vt[i].txe_n, vt[i].rxf_n, vt[i].tx, vt[i].rx);
            wait_req(6, cyc);
            if (vt[i].exp_req) begin
                chk($sformatf("vec%0d_latency", i), cyc, 3);
                if (cyc > 0) begin
                    iTXE_N = 1'b1;
                    iRXF_N = 1'b1;
                    run_burst(vt[i].exp_dir, vt[i].exp_len, vt[i].exp_len, 1'b0, n);
                end
            end else begin
                chk($sformatf("vec%0d_no_req", i), cyc, -1);
                chk($sformatf("vec%0d_idle", i), oBUSY, 0);
            end
            settle();
        end

        // Both directions held eligible above the cap: alternation and done-to-req gap
        apply(1, 0, 0, 1000, 1000);
        wait_req(6, cyc);
        chk("alt_first_req", cyc > 0, 1);
        for (int i = 0; i < 4; i++) begin
            predict(1, 0, 0, 1000, 1000, pr, pd, pl);
            if (i == 3) begin
                iTXE_N = 1'b1;
                iRXF_N = 1'b1;
            end
            run_burst(pd, pl, pl, 1'b0, n);
            if (i < 3) begin
                wait_req(6, cyc);
                chk($sformatf("alt_gap%0d", i), n + cyc, TURN_CYC + 2);
            end
        end
        settle();

        // Early termination is legal
        apply(1, 0, 1, 50, 900);
        wait_req(6, cyc);
        chk("early_req", cyc, 3);
        iTXE_N = 1'b1;
        run_burst(1'b1, 50, 20, 1'b0, n);
        chk("early_no_err", oERR, 0);
        settle();

        // Withdrawal keeps the round-robin pointer; then ack+done together
        apply(1, 0, 0, 1000, 1000);
        wait_req(6, cyc);
        predict(1, 0, 0, 1000, 1000, pr, pd, pl);
        chk("wd_dir", oDIR, pd);
        step();
        chk("wd_req_hold", oREQ, 1);
        iENABLE = 1'b0;
        step();
        chk("wd_req_low", oREQ, 0);
        chk("wd_idle", oBUSY, 0);
        step();
        chk("wd_stays_low", oREQ, 0);
        iENABLE = 1'b1;
        wait_req(6, cyc);
        chk("wd_rereq", cyc > 0, 1);
        run_burst(pd, pl, pl, 1'b1, n);
        wait_req(6, cyc);
        chk("ackdone_gap", n + cyc, TURN_CYC + 2);
        predict(1, 0, 0, 1000, 1000, pr, pd, pl);
        iTXE_N = 1'b1;
        iRXF_N = 1'b1;
        run_burst(pd, pl, 0, 1'b0, n);
        settle();

        // Randomized arbitration and engine behaviour against the model
        for (int it = 0; it < 60; it++) begin
            en    = ($urandom_range(0, 9) != 0);
            txe_n = 1'($urandom_range(0, 1));
            rxf_n = 1'($urandom_range(0, 1));
            tx = 0; rx = 0;
            for (int k = 0; k < 2; k++) begin
                case ($urandom_range(0, 4))
                    0:       pl = 0;
                    1:       pl = int'($urandom_range(1, 50));
                    2:       pl = int'($urandom_range(255, 257));
                    3:       pl = int'($urandom_range(258, 2047));
                    default: pl = int'($urandom_range(100, 254));
                endcase
                if (k == 0) tx = pl;
                else        rx = pl;
            end
            predict(en, txe_n, rxf_n, tx, rx, pr, pd, pl);
            apply(en, txe_n, rxf_n, tx, rx);
            wait_req(6, cyc);
            if (!pr) begin
                chk("rnd_no_req", cyc, -1);
            end else begin
                chk("rnd_latency", cyc, 3);
                if (cyc > 0) begin
                    iTXE_N = 1'b1;
                    iRXF_N = 1'b1;
                    act = int'($urandom_range(0, 3));
                    if (act == 0) begin
                        chk("rnd_wd_dir", oDIR, pd);
                        chk("rnd_wd_len", oLEN, pl);
                        iENABLE = 1'b0;
                        step();
                        chk("rnd_wd_req", oREQ, 0);
                        chk("rnd_wd_idle", oBUSY, 0);
                    end else begin
                        run_burst(pd, pl, int'($urandom_range(0, pl)), act == 1, n);
                    end
                end
            end
            settle();
        end

        // Over-report sets a sticky error
        apply(1, 0, 1, 10, 900);
        wait_req(6, cyc);
        chk("over_req", cyc, 3);
        iTXE_N = 1'b1;
        run_burst(1'b1, 10, 11, 1'b0, n);
        chk("over_err", oERR, 1);
        settle();
        apply(1, 1, 0, 900, 30);
        wait_req(6, cyc);
        chk("sticky_req", cyc, 3);
        iRXF_N = 1'b1;
        run_burst(1'b0, 30, 30, 1'b0, n);
        chk("sticky_err", oERR, 1);
        settle();

        // Asynchronous reset in the middle of a burst
        apply(1, 0, 1, 40, 900);
        wait_req(6, cyc);
        chk("mid_req", cyc, 3);
        iTXE_N = 1'b1;
        iACK   = 1'b1;
        step();
        iACK = 1'b0;
        chk("mid_running", oBUSY, 1);
        #3;
        iRESET = 1'b0;
        #1;
        chk("arst_busy", oBUSY, 0);
        chk("arst_req", oREQ, 0);
        chk("arst_len", oLEN, 0);
        chk("arst_dir", oDIR, 0);
        chk("arst_err", oERR, 0);
        chk("arst_tx_words", oTX_WORDS, 0);
        chk("arst_rx_words", oRX_WORDS, 0);
        m_last = 1'b1; m_err = 1'b0; m_tx = '0; m_rx = '0;
        apply(1, 0, 0, 1000, 1000);
        repeat (2) step();
        iRESET = 1'b1;
        wait_req(8, cyc);
        chk("post_rst_req", cyc > 0, 1);
        predict(1, 0, 0, 1000, 1000, pr, pd, pl);
        chk("post_rst_read", oDIR, 0);
        iTXE_N = 1'b1;
        iRXF_N = 1'b1;
        run_burst(pd, pl, pl, 1'b0, n);
        settle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
